// File: rtl/bsg_tanh_pack_q7.sv
// rtl/bsg_tanh_pack_q7.sv - quantize signed tanh samples to Q(out_width_p-1) and pack lanes into words
// Round half away from zero, symmetric saturation, sticky saturation flag, one-deep output register.
module bsg_tanh_pack_q7 #(
   parameter int ans_width_p = 32,
   parameter int frac_p      = 16,
   parameter int out_width_p = 8,
   parameter int lanes_p     = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [ans_width_p-1:0]           data_i,
   input  logic                             v_i,
   input  logic                             last_i,
   output logic                             ready_o,
   output logic [lanes_p*out_width_p-1:0]   data_o,
   output logic [$clog2(lanes_p+1)-1:0]     count_o,
   output logic                             v_o,
   input  logic                             ready_i,
   output logic                             sat_o
);

   localparam int shift_lp   = frac_p - (out_width_p - 1);
   localparam int cnt_w_lp   = $clog2(lanes_p);
   localparam int count_w_lp = $clog2(lanes_p + 1);

   logic signed [ans_width_p:0] ext, bias, sum, rnd, max_v, min_v;
   logic                        sat;
   logic [out_width_p-1:0]      q;

   // Negative inputs use a bias one short of half so the floor of the shift rounds away from zero.
   always_comb begin
      ext  = {data_i[ans_width_p-1], data_i};
      bias = '0;
      bias[shift_lp-1] = 1'b1;
      if (data_i[ans_width_p-1])
         bias = bias - {{ans_width_p{1'b0}}, 1'b1};
      sum   = ext + bias;
      rnd   = sum >>> shift_lp;
      max_v = '0;
      max_v[out_width_p-2:0] = '1;
      min_v = -max_v;
      sat   = (rnd > max_v) || (rnd < min_v);
      if (rnd > max_v)
         q = max_v[out_width_p-1:0];
      else if (rnd < min_v)
         q = min_v[out_width_p-1:0];
      else
         q = rnd[out_width_p-1:0];
   end

   logic                           accept, last_lane, complete;
   logic [lanes_p*out_width_p-1:0] pack_r, pack_nxt;
   logic [cnt_w_lp-1:0]            cnt_r;

   assign ready_o   = ~v_o | ready_i;
   assign accept    = v_i & ready_o;
   assign last_lane = (cnt_r == cnt_w_lp'(lanes_p - 1));
   assign complete  = accept & (last_lane | last_i);

   always_comb begin
      pack_nxt = pack_r;
      for (int k = 0; k < lanes_p; k++)
         if (cnt_r == cnt_w_lp'(k))
            pack_nxt[k*out_width_p +: out_width_p] = q;
   end

   // A completing beat reloads the output register even while it drains, giving full throughput.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pack_r  <= '0;
         cnt_r   <= '0;
         data_o  <= '0;
         count_o <= '0;
         v_o     <= 1'b0;
         sat_o   <= 1'b0;
      end else begin
         if (accept & sat)
            sat_o <= 1'b1;
         if (complete) begin
            data_o  <= pack_nxt;
            count_o <= count_w_lp'(cnt_r) + count_w_lp'(1);
            v_o     <= 1'b1;
            pack_r  <= '0;
            cnt_r   <= '0;
         end else begin
            if (accept) begin
               pack_r <= pack_nxt;
               cnt_r  <= cnt_r + cnt_w_lp'(1);
            end
            if (v_o & ready_i)
               v_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bsg_tanh_pack_q7.sv
// tb/tb_bsg_tanh_pack_q7.sv - self-checking bench for bsg_tanh_pack_q7
// Scoreboard model quantizes with plain integer arithmetic and assembles words from a lane queue.
module tb_bsg_tanh_pack_q7;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] data_i = '0;
   logic        v_i = 1'b0;
   logic        last_i = 1'b0;
   logic        ready_o;
   logic [31:0] data_o;
   logic [2:0]  count_o;
   logic        v_o;
   logic        ready_i = 1'b1;
   logic        sat_o;

   bsg_tanh_pack_q7 dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data_i),
      .v_i     (v_i),
      .last_i  (last_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .count_o (count_o),
      .v_o     (v_o),
      .ready_i (ready_i),
      .sat_o   (sat_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  c;
   } word_t;

   word_t       exp_q[$];
   logic [7:0]  lane_q[$];
   bit          m_sat = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_words = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] quant(input logic [31:0] d, output bit sat);
      longint x, mag, r;
      x   = longint'(signed'(d));
      mag = (x < 0) ? -x : x;
      r   = (mag + 256) / 512;
      if (x < 0) r = -r;
      sat = 0;
      if (r > 127) begin r = 127; sat = 1; end
      if (r < -127) begin r = -127; sat = 1; end
      return 8'(r);
   endfunction

   task automatic model_beat(input logic [31:0] d, input bit last);
      bit    s;
      word_t w;
      lane_q.push_back(quant(d, s));
      if (s) m_sat = 1;
      if (lane_q.size() == 4 || last) begin
         w.d = '0;
         for (int i = 0; i < lane_q.size(); i++) w.d[i*8 +: 8] = lane_q[i];
         w.c = 3'(lane_q.size());
         exp_q.push_back(w);
         lane_q.delete();
      end
   endtask

   task automatic step(output bit acc);
      word_t w;
      @(negedge clk);
      acc = 0;
      if (!reset_i) begin
         check_eq("v_o", v_o, exp_q.size() != 0);
         check_eq("ready_o", ready_o, (exp_q.size() == 0) || ready_i);
         check_eq("sat_o", sat_o, m_sat);
         if (v_o && ready_i) begin
            if (exp_q.size() == 0)
               check_eq("unexpected_word", v_o, 0);
            else begin
               w = exp_q.pop_front();
               check_eq("word_data", data_o, w.d);
               check_eq("word_count", count_o, w.c);
               n_words++;
            end
         end
         acc = v_i && ready_o;
         if (acc) model_beat(data_i, last_i);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input bit last, output int tries);
      bit acc;
      v_i = 1; data_i = d; last_i = last;
      tries = 0;
      acc = 0;
      while (!acc && tries < 20) begin
         step(acc);
         tries++;
      end
      if (!acc) check_eq("send_timeout", acc, 1);
   endtask

   task automatic do_reset();
      v_i = 0; last_i = 0; reset_i = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_i = 0;
      exp_q.delete(); lane_q.delete(); m_sat = 0;
   endtask

   task automatic idle(input int n);
      bit acc;
      v_i = 0; last_i = 0;
      for (int i = 0; i < n; i++) step(acc);
   endtask

   logic [31:0] held;
   int          t, stalls, words0;
   bit          a;

   initial begin
      do_reset();
      check_eq("rst_v_o", v_o, 0);
      check_eq("rst_data_o", data_o, 0);
      check_eq("rst_count_o", count_o, 0);
      check_eq("rst_sat_o", sat_o, 0);
      check_eq("rst_ready_o", ready_o, 1);

      // basic word with saturation
      ready_i = 1;
      send(32'h00008000, 0, t);
      send(32'h00010000, 0, t);
      send(32'hFFFF8000, 0, t);
      check_eq("t1_v_early", v_o, 0);
      send(32'h00000000, 0, t);
      check_eq("t1_v", v_o, 1);
      check_eq("t1_data", data_o, 32'h00C07F40);
      check_eq("t1_count", count_o, 4);
      check_eq("t1_sat", sat_o, 1);
      idle(1);

      // rounding
      send(32'h00000100, 0, t);
      send(32'hFFFFFF00, 0, t);
      send(32'h000000FF, 0, t);
      send(32'hFFFF0000, 0, t);
      check_eq("t2_data", data_o, 32'h8100FF01);
      idle(1);

      // early close with last_i, and last_i on first lane
      send(32'h00008000, 0, t);
      send(32'h00004000, 1, t);
      check_eq("t3_data", data_o, 32'h00002040);
      check_eq("t3_count", count_o, 2);
      idle(1);
      send(32'h00004000, 1, t);
      check_eq("t3b_count", count_o, 1);
      idle(1);

      // backpressure
      ready_i = 0;
      for (int i = 0; i < 4; i++) send($urandom, 0, t);
      held = data_o;
      v_i = 1; data_i = 32'h00001200; last_i = 0;
      for (int i = 0; i < 5; i++) begin
         step(a);
         check_eq("bp_ready", ready_o, 0);
         check_eq("bp_hold", data_o, held);
         check_eq("bp_noacc", a, 0);
      end
      ready_i = 1;
      #1;
      check_eq("bp_ready_same", ready_o, 1);
      step(a);
      check_eq("bp_acc_on_drain", a, 1);
      idle(1);

      // reset mid-word
      send(32'h00020000, 0, t);
      send(32'h00030000, 0, t);
      do_reset();
      for (int i = 0; i < 4; i++) send(32'h00008000, 0, t);
      check_eq("t5_data", data_o, 32'h40404040);
      check_eq("t5_count", count_o, 4);
      idle(1);
      check_eq("t5_sat", sat_o, 0);

      // streaming
      stalls = 0;
      words0 = n_words;
      ready_i = 1;
      for (int i = 0; i < 12; i++) begin
         send($urandom_range(0, 32'h0000FFFF), 0, t);
         stalls += t - 1;
      end
      idle(2);
      check_eq("stream_stalls", stalls, 0);
      check_eq("stream_words", n_words - words0, 3);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         v_i    = ($urandom % 4) != 0;
         last_i = ($urandom % 5) == 0;
         ready_i = ($urandom % 3) != 0;
         case ($urandom % 4)
            0: data_i = $urandom;
            1: data_i = $urandom_range(0, 32'h00020000);
            2: data_i = -$urandom_range(0, 32'h00020000);
            default: data_i = ($urandom_range(0, 600) - 300) * 512 + 256;
         endcase
         step(a);
      end
      ready_i = 1;
      send(32'h0, 1, t);
      idle(3);
      check_eq("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_tanh_pack_q7.md
BSG_TANH_PACK_Q7 -- requirements
Module: bsg_tanh_pack_q7

Interface
- REQ-001 The block SHALL have parameter ans_width_p, default 32, meaning width of the signed fixed-point tanh sample input.
- REQ-002 The block SHALL have parameter frac_p, default 16, meaning number of fractional bits in the input sample.
- REQ-003 The block SHALL have parameter out_width_p, default 8, meaning signed output lane width, Q(out_width_p-1) format.
- REQ-004 The block SHALL have parameter lanes_p, default 4, meaning lanes packed per output word; lanes_p >= 2.
- REQ-005 The block SHALL have one clock, clk_i, input, 1 bit, with all state updated on its rising edge.
- REQ-006 The block SHALL have reset_i, input, 1 bit; reset is synchronous and active-high.
- REQ-007 The block SHALL have data_i, input, ans_width_p bits, signed tanh sample.
- REQ-008 The block SHALL have v_i, input, 1 bit, input valid.
- REQ-009 The block SHALL have last_i, input, 1 bit, qualified by v_i; it closes the current word after this sample.
- REQ-010 The block SHALL have ready_o, output, 1 bit, input ready; a beat transfers when v_i & ready_o.
- REQ-011 The block SHALL have data_o, output, lanes_p*out_width_p bits, packed word with lane k in bits [k*out_width_p +: out_width_p].
- REQ-012 The block SHALL have count_o, output, $clog2(lanes_p+1) bits, number of valid lanes in data_o (1..lanes_p).
- REQ-013 The block SHALL have v_o, output, 1 bit, output word valid.
- REQ-014 The block SHALL have ready_i, input, 1 bit, consumer ready; a word transfers when v_o & ready_i.
- REQ-015 The block SHALL have sat_o, output, 1 bit, sticky flag set when any accepted sample saturated.

Function
- REQ-016 Quantization SHALL be q = data_i arithmetically shifted right by s = frac_p-(out_width_p-1) bits (s = 9 at defaults).
- REQ-017 Rounding SHALL be round-half-away-from-zero on the discarded s bits, computed in at least ans_width_p+1 bits.
- REQ-018 After rounding, the result SHALL saturate symmetrically to [-(2^(out_width_p-1)-1), +(2^(out_width_p-1)-1)], i.e. [-127, +127] at defaults.
- REQ-019 sat_o SHALL go high the cycle after an accepted beat that saturated, and SHALL remain high until reset.
- REQ-020 State SHALL consist of a pack register, lane counter cnt_r (0..lanes_p-1), output register data_o/count_o, and v_o.
- REQ-021 An accepted beat SHALL write its quantized lane at index cnt_r.
- REQ-022 The word SHALL complete on the beat where cnt_r == lanes_p-1 or last_i == 1.
- REQ-023 On an incomplete beat, cnt_r SHALL increment.
- REQ-024 On a completing beat, the pack contents plus the new lane SHALL move to data_o, count_o SHALL be set to cnt_r+1, unwritten lanes SHALL be zero, v_o SHALL be set the next cycle (latency 1), and the pack register and cnt_r SHALL clear.
- REQ-025 ready_o SHALL equal ~v_o | ready_i (combinational from ready_i, no path from v_i/data_i).
- REQ-026 When v_o & ready_i and no completing beat occurs in the same cycle, v_o SHALL clear next cycle.
- REQ-027 A simultaneous drain and completing beat SHALL load the new word with v_o remaining 1, so full throughput is one word per lanes_p cycles.
- REQ-028 While v_o & ~ready_i, data_o and count_o SHALL be held stable and no beat SHALL be accepted.
- REQ-029 last_i on the first lane SHALL produce count_o = 1; last_i without v_i SHALL be ignored.
- REQ-030 The block SHALL have no internal FSM beyond the counter and valid bit; there SHALL be no timeout or auto-flush.

Reset
- REQ-031 While reset_i is high at a rising edge, the block SHALL clear v_o, cnt_r, pack register, data_o, count_o and sat_o to 0.
- REQ-032 A partial word present at reset SHALL be discarded.
- REQ-033 ready_o SHALL be 1 in the first cycle after reset deassertion.

Verification
- REQ-034 The bench SHALL cover: inputs 0x00008000, 0x00010000, 0xFFFF8000, 0x00000000, no last_i, ready_i=1 -> one word with data_o=0x00C07F40, count_o=4, v_o one cycle after the 4th beat, and sat_o=1.
- REQ-035 The bench SHALL cover rounding: inputs 0x00000100, 0xFFFFFF00, 0x000000FF, 0xFFFF0000 -> lanes 0x01, 0xFF, 0x00, 0x81 (-1.0 clamps to -127), i.e. data_o=0x8100FF01.
- REQ-036 The bench SHALL cover: 0x00008000 then 0x00004000 with last_i=1 -> data_o=0x00002040, count_o=2.
- REQ-037 The bench SHALL cover backpressure: after a completed word, hold ready_i=0 for 5 cycles -> ready_o=0, data_o stable; on ready_i=1 the word drains and ready_o=1 the same cycle.
- REQ-038 The bench SHALL cover reset mid-word: accept 2 beats, pulse reset_i, send 4 beats of 0x00008000 -> a single word 0x40404040, count_o=4, and sat_o=0.
- REQ-039 The bench SHALL cover streaming: 12 back-to-back beats with ready_i held at 1 -> 3 words, with no beat ever stalled.
